// File: rtl/bcd_display_scan.sv
// Four-digit common-anode 7-segment scanner for a latched BCD result word.
// Define LEADING_ZERO_BLANK_EN to suppress leading zero digits.
module bcd_display_scan #(
    parameter int REFRESH_DIV = 27000,
    parameter int CNT_W       = $clog2(REFRESH_DIV)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            clear,
    input  logic [3:0][3:0] resultado,
    output logic [3:0]      an,
    output logic [6:0]      seg,
    output logic            busy
);

    localparam logic [CNT_W-1:0] TC = CNT_W'(REFRESH_DIV - 1);

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    logic [3:0][3:0]  value_q, value_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       dig_q, dig_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             tc;
    logic [3:0]       supp;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value_q <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
            dig_q   <= 2'd0;
            an_q    <= 4'b1111;
            seg_q   <= 7'b1111111;
        end else begin
            value_q <= value_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            dig_q   <= dig_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic z3, z2, z1;
    assign z3 = (value_q[3] == 4'd0);
    assign z2 = (value_q[2] == 4'd0);
    assign z1 = (value_q[1] == 4'd0);
    // a digit goes dark only if it and all higher digits are zero
    assign supp = {z3, z3 & z2, z3 & z2 & z1, 1'b0};
`else
    assign supp = 4'b0000;
`endif

    always_comb begin
        value_d = value_q;
        valid_d = valid_q;
        if (clear) begin
            valid_d = 1'b0;
        end else if (load) begin
            value_d = resultado;
            valid_d = 1'b1;
        end
    end

    always_comb begin
        tc    = (cnt_q == TC);
        cnt_d = tc ? '0 : cnt_q + CNT_W'(1);
        dig_d = tc ? dig_q + 2'd1 : dig_q;
    end

    // the slot after a wrap is dark so the old digit never ghosts
    always_comb begin
        an_d  = 4'b1111;
        seg_d = 7'b1111111;
        if (!tc && valid_q && !supp[dig_q]) begin
            an_d[dig_q] = 1'b0;
            seg_d       = decode(value_q[dig_q]);
        end
    end

    assign an   = an_q;
    assign seg  = seg_q;
    assign busy = valid_q;

endmodule
